// File: rtl/mmu_tile_sequencer.sv
// Tile sequencer for an N x N output-stationary FP8 MAC array: operand reads, skewed lane valids,
// diagonal clear wavefront and result handshake. Define MMU_SEQ_PERF_CNT_EN to add performance counters.
module mmu_tile_sequencer #(
  parameter int N      = 4,
  parameter int K_W    = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [K_W-1:0]    cmd_k,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [N-1:0]      lane_valid,
  output logic [2*N-2:0]    clear_diag,
  output logic              busy,
  output logic              res_valid,
`ifdef MMU_SEQ_PERF_CNT_EN
  output logic [31:0]       perf_busy_cycles,
  output logic [15:0]       perf_tiles,
`endif
  input  logic              res_ready
);

  localparam int CNT_W = K_W + 6;
  localparam int D_W   = 2 * N - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  t_r;
  logic [CNT_W-1:0]  t_nxt_s;
  logic [K_W-1:0]    k_r;
  logic [K_W-1:0]    k_nxt_s;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] base_nxt_s;
  logic [CNT_W-1:0]  m_s;
  logic [CNT_W-1:0]  k_nxt_ext_s;
  logic              active_nxt_s;
  logic              rd_en_nxt_s;
  logic [ADDR_W-1:0] rd_addr_nxt_s;
  logic [N-1:0]      lane_nxt_s;
  logic [D_W-1:0]    clear_nxt_s;

  assign cmd_ready = (state_r == ST_IDLE);

  // Next state, tile-relative cycle counter t (0 at the first FEED cycle) and latched command
  always_comb begin
    state_nxt_s = state_r;
    t_nxt_s     = t_r;
    k_nxt_s     = k_r;
    base_nxt_s  = base_r;
    m_s         = (k_r == {K_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : CNT_W'(k_r);
    case (state_r)
      ST_IDLE: begin
        t_nxt_s = {CNT_W{1'b0}};
        if (cmd_valid) begin
          state_nxt_s = ST_FEED;
          k_nxt_s     = cmd_k;
          base_nxt_s  = cmd_base;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FEED: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
          t_nxt_s     = {CNT_W{1'b0}};
        end else begin
          t_nxt_s = t_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (t_r == m_s - {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_FEED;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
          t_nxt_s     = {CNT_W{1'b0}};
        end else begin
          t_nxt_s = t_r + {{(CNT_W-1){1'b0}}, 1'b1};
          // Last accumulate of PE(N-1,N-1) happens at t = max(K,1) + 2N-2
          if (t_r == m_s + CNT_W'(2 * N - 2)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
      end
      ST_DONE: begin
        if (abort || res_ready) begin
          state_nxt_s = ST_IDLE;
          t_nxt_s     = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        t_nxt_s     = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output values for the coming cycle, decoded from next state so the outputs can be registered
  always_comb begin
    k_nxt_ext_s   = CNT_W'(k_nxt_s);
    active_nxt_s  = (state_nxt_s == ST_FEED) || (state_nxt_s == ST_DRAIN);
    rd_en_nxt_s   = (state_nxt_s == ST_FEED) && (t_nxt_s < k_nxt_ext_s);
    rd_addr_nxt_s = {ADDR_W{1'b0}};
    lane_nxt_s    = {N{1'b0}};
    clear_nxt_s   = {D_W{1'b0}};
    if (rd_en_nxt_s) begin
      rd_addr_nxt_s = base_nxt_s + ADDR_W'(t_nxt_s);
    end else begin
      rd_addr_nxt_s = {ADDR_W{1'b0}};
    end
    // Lane i sees buffer data one read-latency cycle plus i skew registers after the read
    for (int i = 0; i < N; i++) begin
      lane_nxt_s[i] = active_nxt_s && (k_nxt_s != {K_W{1'b0}}) &&
                      (t_nxt_s >= CNT_W'(i + 1)) && (t_nxt_s <= k_nxt_ext_s + CNT_W'(i));
    end
    for (int d = 0; d < D_W; d++) begin
      clear_nxt_s[d] = active_nxt_s && (t_nxt_s == CNT_W'(d + 1));
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      t_r        <= {CNT_W{1'b0}};
      k_r        <= {K_W{1'b0}};
      base_r     <= {ADDR_W{1'b0}};
      rd_en      <= 1'b0;
      rd_addr    <= {ADDR_W{1'b0}};
      lane_valid <= {N{1'b0}};
      clear_diag <= {D_W{1'b0}};
      busy       <= 1'b0;
      res_valid  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      t_r        <= t_nxt_s;
      k_r        <= k_nxt_s;
      base_r     <= base_nxt_s;
      rd_en      <= rd_en_nxt_s;
      rd_addr    <= rd_addr_nxt_s;
      lane_valid <= lane_nxt_s;
      clear_diag <= clear_nxt_s;
      busy       <= active_nxt_s;
      res_valid  <= (state_nxt_s == ST_DONE);
    end
  end

`ifdef MMU_SEQ_PERF_CNT_EN
  // Saturating busy-cycle count and wrapping count of tiles drained through res_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles <= 32'd0;
      perf_tiles       <= 16'd0;
    end else begin
      if (busy && (perf_busy_cycles != 32'hFFFF_FFFF)) begin
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end else begin
        perf_busy_cycles <= perf_busy_cycles;
      end
      if ((state_r == ST_DONE) && res_ready && !abort) begin
        perf_tiles <= perf_tiles + 16'd1;
      end else begin
        perf_tiles <= perf_tiles;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mmu_tile_sequencer.sv
// Directed self-checking bench for mmu_tile_sequencer (N=4, K_W=8, ADDR_W=8).
module tb_mmu_tile_sequencer;

  localparam int N = 4;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_k;
  logic [7:0] cmd_base;
  logic       abort;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [3:0] lane_valid;
  logic [6:0] clear_diag;
  logic       busy;
  logic       res_valid;
  logic       res_ready;
`ifdef MMU_SEQ_PERF_CNT_EN
  logic [31:0] perf_busy_cycles;
  logic [15:0] perf_tiles;
`endif

  int checks;
  int errors;

  mmu_tile_sequencer #(.N(4), .K_W(8), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_k      (cmd_k),
    .cmd_base   (cmd_base),
    .abort      (abort),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .lane_valid (lane_valid),
    .clear_diag (clear_diag),
    .busy       (busy),
    .res_valid  (res_valid),
`ifdef MMU_SEQ_PERF_CNT_EN
    .perf_busy_cycles (perf_busy_cycles),
    .perf_tiles       (perf_tiles),
`endif
    .res_ready  (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs expected while no tile is running
  task automatic chk_idle(input string tag);
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    chk({tag, " rd_en"}, rd_en, 0);
    chk({tag, " lane_valid"}, lane_valid, 0);
    chk({tag, " clear_diag"}, clear_diag, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " res_valid"}, res_valid, 0);
  endtask

  // Expected outputs at tile-relative cycle t (T0 = 0) while in FEED or DRAIN
  task automatic chk_cycle(input int k, input int base, input int t);
    logic [3:0] lane_e;
    logic [6:0] clr_e;
    string tg;
    tg = $sformatf("k%0d t%0d", k, t);
    for (int i = 0; i < N; i++) lane_e[i] = (k != 0) && (t >= 1 + i) && (t <= k + i);
    for (int d = 0; d < 2 * N - 1; d++) clr_e[d] = (t == 1 + d);
    chk({tg, " rd_en"}, rd_en, (t < k));
    if (t < k) chk({tg, " rd_addr"}, rd_addr, (base + t) & 8'hFF);
    chk({tg, " lane_valid"}, lane_valid, lane_e);
    chk({tg, " clear_diag"}, clear_diag, clr_e);
    chk({tg, " busy"}, busy, 1);
    chk({tg, " res_valid"}, res_valid, 0);
    chk({tg, " cmd_ready"}, cmd_ready, 0);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, " res_valid"}, res_valid, 1);
    chk({tag, " cmd_ready"}, cmd_ready, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " rd_en"}, rd_en, 0);
    chk({tag, " lane_valid"}, lane_valid, 0);
    chk({tag, " clear_diag"}, clear_diag, 0);
  endtask

  // Issue a command from IDLE; returns sampling at T0
  task automatic start_tile(input int k, input int base);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_k     = k[7:0];
    cmd_base  = base[7:0];
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Full tile: checks every cycle, holds res_ready low for 'hold' DONE cycles
  task automatic run_tile(input int k, input int base, input int hold);
    int m;
    m = (k == 0) ? 1 : k;
    start_tile(k, base);
    for (int t = 0; t < m + 2 * N - 1; t++) begin
      chk_cycle(k, base, t);
      @(negedge clk);
    end
    for (int h = 0; h < hold; h++) begin
      chk_done($sformatf("k%0d hold%0d", k, h));
      cmd_valid = (h == 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk_done($sformatf("k%0d done", k));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk_idle($sformatf("k%0d exit", k));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_k     = 8'd0;
    cmd_base  = 8'd0;
    abort     = 1'b0;
    res_ready = 1'b0;
    #1;
    chk_idle("reset");
    chk("reset rd_addr", rd_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post reset");

    // abort in IDLE has no effect
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("idle abort");

    run_tile(3, 8'h10, 5);
    run_tile(0, 8'h20, 0);
    run_tile(4, 8'hFE, 1);

    // abort at T0+2 of a K=8 tile
    start_tile(8, 8'h40);
    for (int t = 0; t < 3; t++) begin
      chk_cycle(8, 8'h40, t);
      if (t == 2) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    chk_idle("abort T0+3");
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk($sformatf("abort quiet %0d res_valid", c), res_valid, 0);
      chk($sformatf("abort quiet %0d busy", c), busy, 0);
    end
    run_tile(2, 8'h80, 2);

    // asynchronous reset pulse mid-DRAIN (K=3, t=5)
    start_tile(3, 8'h00);
    for (int t = 0; t < 6; t++) begin
      chk_cycle(3, 8'h00, t);
      if (t < 5) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async reset");
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle("after async reset");

`ifdef MMU_SEQ_PERF_CNT_EN
    chk("perf_tiles reset", perf_tiles, 0);
    chk("perf_busy reset", perf_busy_cycles, 0);
    run_tile(3, 8'h00, 0);
    run_tile(3, 8'h30, 2);
    chk("perf_tiles", perf_tiles, 2);
    chk("perf_busy_cycles", perf_busy_cycles, 20);
`endif

    run_tile(1, 8'h05, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mmu_tile_sequencer.md
Name: mmu_tile_sequencer

Overview:
- Controls one N×N output-stationary array of FP8×FP8→BF16 multiply-accumulate PEs.
- Accepts a tile command (inner dimension K, operand buffer base address) and issues operand-buffer reads.
- Generates per-lane injection valids for the skewed edge feeders, and the wavefront of diagonal clear pulses that restarts the PE accumulators.
- Holds the finished accumulators under a valid/ready handshake until they are drained.

Parameters:
- N, 4, array dimension (rows = columns); supported range 2..16
- K_W, 8, width of the K count
- ADDR_W, 8, operand buffer address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  tile command valid
- cmd_ready  out  1  sequencer idle, command accepted when valid&ready
- cmd_k  in  K_W  inner dimension, number of operand steps (0 allowed)
- cmd_base  in  ADDR_W  buffer address of step 0
- abort  in  1  synchronous cancel of the current tile
- rd_en  out  1  operand buffer read strobe (A column and B row, shared address)
- rd_addr  out  ADDR_W  read address
- lane_valid  out  N  bit i: row-i A feeder and column-i B feeder pass buffer data; else inject 8'h00
- clear_diag  out  2N-1  bit d: clear to all PEs with row+col = d
- busy  out  1  tile in progress (FEED or DRAIN)
- res_valid  out  1  accumulators final and stable
- res_ready  in  1  result consumer has read the array

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, all counters 0, all outputs 0 except cmd_ready = 1.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid, latch K and base and go to FEED. T0 = first FEED cycle.
  - FEED: step counter s runs 0..max(K,1)-1.
    - rd_en = (s < K); rd_addr = base + s, wrapping mod 2^ADDR_W.
    - After the last step go to DRAIN.
  - DRAIN: cycle counter runs until cycle T0+max(K,1)+2N-2 inclusive, then go to DONE.
  - DONE: res_valid = 1. Stay until res_ready, then go to IDLE. Zero-cycle handshake allowed: res_ready high on the first DONE cycle exits the next cycle.
- Read latency:
  - The buffer returns data one cycle after rd_en.
  - The external feeder skews lane i by i registers.
  - Therefore lane_valid[i] is high exactly on cycles T0+1+i .. T0+K+i; it is never high when K = 0.
- Clear wavefront:
  - PE(i,j) receives step 0 at cycle T0+1+i+j.
  - clear_diag[d] is a single-cycle pulse at T0+1+d, for d = 0..2N-2, independent of K.
  - With K = 0, clears coincide with zero injection, so all accumulators become +0.
- Result timing: the last accumulate of PE(N-1,N-1) is at T0+max(K,1)+2N-2, so res_valid rises at T0+max(K,1)+2N-1.
- busy = 1 in FEED and DRAIN only. cmd_ready = 0 outside IDLE; commands are never queued.
- abort:
  - Sampled in FEED, DRAIN or DONE; next cycle the state is IDLE.
  - rd_en, lane_valid, clear_diag and res_valid are 0 from that cycle, and no res_valid is produced for the tile.
  - Ignored in IDLE. abort has priority over res_ready.
- Reset mid-tile behaves as abort; the array contents are undefined afterwards, and the next tile's clears restore them.
- All outputs are registered except cmd_ready, which is decoded from state.

Optional Feature:
- Macro: MMU_SEQ_PERF_CNT_EN.
- Defined: adds two outputs.
  - perf_busy_cycles (32 bits): increments every cycle busy = 1, saturates at all-ones.
  - perf_tiles (16 bits): increments on each DONE→IDLE exit via res_ready, wraps, not on abort.
  - Both are reset to 0 by rst_n only.
- Not defined: the ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- N=4, K=3, base=0x10 → rd_en at T0..T0+2 with rd_addr 0x10,0x11,0x12; lane_valid[2] high T0+3..T0+5; clear_diag[d] single pulse at T0+1+d; res_valid rises at T0+10.
- K=0 → no rd_en, lane_valid never set, clear_diag pulses T0+1..T0+7, res_valid at T0+8; with the array attached, all c_out = 16'h0000.
- base=0xFE, K=4 → rd_addr 0xFE,0xFF,0x00,0x01.
- res_ready held low for 5 cycles in DONE → res_valid and cmd_ready stable (1, 0); a cmd_valid during DONE is not accepted; res_ready=1 → IDLE next cycle.
- abort at T0+2 of K=8 → rd_en/lane_valid/clear_diag 0 from T0+3, no res_valid, cmd_ready=1 at T0+3; a new command then runs to correct completion.
- rst_n pulsed low mid-DRAIN (asynchronous, between edges) → outputs 0 and cmd_ready=1 immediately; with MMU_SEQ_PERF_CNT_EN, after two completed K=3 tiles perf_tiles=2 and perf_busy_cycles=20.
